// File: rtl/ewh_pkg.sv
// rtl/ewh_pkg.sv - shared state encoding, constants and saturating helper for the target hit detector
package ewh_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        WATCH  = 2'd2,
        HIT    = 2'd3
    } ewh_state_e;

    localparam logic [3:0] NO_TARGET = 4'hF;
    localparam int         CNT_W     = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - two-flop synchronizer and debounce filter for one photo sensor bit
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic filtered
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The counter only runs while the synchronized bit disagrees with the filtered bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            filtered <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (sync2 == filtered) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filtered <= ~filtered;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/target_hit_detector.sv
// rtl/target_hit_detector.sv - per-channel laser hit detector; miss reporting under TARGET_HIT_MISS_EN
module target_hit_detector
    import ewh_pkg::*;
#(
    parameter int NUM_SENSORS     = 10,
    parameter int TARGET_W        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ARM_DELAY       = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SENSORS-1:0] photo_array,
    input  logic [TARGET_W-1:0]    target_active,
    input  logic                   hit_clear,
    output logic                   active_is_hit,
    output logic                   armed,
    output logic [CNT_W-1:0]       hit_count,
    output logic                   miss_pulse,
    output logic [CNT_W-1:0]       miss_count
);

    localparam int                AW        = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
    localparam logic [AW-1:0]     ARM_LAST  = AW'(ARM_DELAY - 1);
    localparam logic [TARGET_W:0] NUM_LIMIT = (TARGET_W + 1)'(NUM_SENSORS);

    logic [NUM_SENSORS-1:0] filtered;
    logic [NUM_SENSORS-1:0] filtered_d;
    logic [NUM_SENSORS-1:0] rise;
    logic [NUM_SENSORS-1:0] target_mask;
    logic [TARGET_W-1:0]    target_reg;
    logic                   target_change;
    logic                   new_valid;
    logic                   target_hit;
    ewh_state_e             state, state_n;
    logic [AW-1:0]          arm_cnt, arm_cnt_n;
    logic                   hit_inc;
    logic [CNT_W-1:0]       hit_count_q;

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_sensor
        sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock   (clock),
            .reset   (reset),
            .pin     (photo_array[i]),
            .filtered(filtered[i])
        );
    end

    assign rise          = filtered & ~filtered_d;
    assign target_change = (target_reg != target_active);
    assign new_valid     = ({1'b0, target_active} < NUM_LIMIT);

    // Compare-based select so an out-of-range target never indexes the sensor vector.
    always_comb begin
        target_mask = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            target_mask[i] = (target_reg == TARGET_W'(i));
        end
    end

    assign target_hit = |(rise & target_mask);

`ifdef TARGET_HIT_MISS_EN
    logic             other_rise;
    logic             miss_inc;
    logic             miss_pulse_q;
    logic [CNT_W-1:0] miss_count_q;

    assign other_rise = |(rise & ~target_mask);
    assign miss_inc   = (state == WATCH) && !target_change && other_rise;
    assign miss_pulse = miss_pulse_q;
    assign miss_count = miss_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            miss_pulse_q <= 1'b0;
            miss_count_q <= '0;
        end else begin
            miss_pulse_q <= miss_inc;
            if (miss_inc) begin
                miss_count_q <= sat_inc(miss_count_q);
            end
        end
    end
`else
    assign miss_pulse = 1'b0;
    assign miss_count = '0;
`endif

    // A target change overrides everything, which also drops a coincident hit.
    always_comb begin
        state_n   = state;
        arm_cnt_n = arm_cnt;
        hit_inc   = 1'b0;
        if (target_change) begin
            state_n   = new_valid ? ARMING : IDLE;
            arm_cnt_n = '0;
        end else begin
            case (state)
                IDLE: state_n = IDLE;
                ARMING: begin
                    if (arm_cnt == ARM_LAST) begin
                        state_n = WATCH;
                    end else begin
                        arm_cnt_n = arm_cnt + 1'b1;
                    end
                end
                WATCH: begin
                    if (target_hit) begin
                        state_n = HIT;
                        hit_inc = 1'b1;
                    end
                end
                HIT: begin
                    if (hit_clear) begin
                        state_n = WATCH;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            arm_cnt     <= '0;
            target_reg  <= TARGET_W'(NO_TARGET);
            filtered_d  <= '0;
            hit_count_q <= '0;
        end else begin
            state      <= state_n;
            arm_cnt    <= arm_cnt_n;
            target_reg <= target_active;
            filtered_d <= filtered;
            if (hit_inc) begin
                hit_count_q <= sat_inc(hit_count_q);
            end
        end
    end

    assign active_is_hit = (state == HIT);
    assign armed         = (state == WATCH);
    assign hit_count     = hit_count_q;

endmodule

// File: doc/target_hit_detector.md
Name: target_hit_detector

Overview:
- Sits between the 10-bit photoresistor array pins and the hit bit the regfile exposes to the game loop (t1hit/t2hit register bit 0). One instance per target channel.
- Synchronizes and debounces every sensor, and arms on each new active target.
- Latches a hit when the sensor of the active target sees a clean laser rising edge. Holds the hit until the processor acknowledges it or the target changes.

Parameters:
- NUM_SENSORS, 10, number of photo sensors; valid target indices are 0..NUM_SENSORS-1.
- TARGET_W, 4, width of the target index.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a filtered sensor bit changes (≥1).
- ARM_DELAY, 8, cycles after a target change before hits are accepted (≥1).

Ports:
- clock, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- photo_array, input, NUM_SENSORS, raw sensor pins, asynchronous; 1 = laser illuminating.
- target_active, input, TARGET_W, current target index; any value ≥ NUM_SENSORS means no target.
- hit_clear, input, 1, single-cycle acknowledge from the processor side.
- active_is_hit, output, 1, latched hit flag.
- armed, output, 1, high while the active target is accepting hits.
- hit_count, output, 16, saturating count of accepted hits.
- miss_pulse, output, 1, see Optional Feature.
- miss_count, output, 16, see Optional Feature.

Behaviour:
- Clock and reset: one clock domain. reset is synchronous and active-high.
- Reset values:
  - active_is_hit=0, armed=0, hit_count=0, miss_pulse=0, miss_count=0.
  - Synchronizer flops=0, filtered bits=0, debounce counters=0.
  - target register=NO_TARGET, state=IDLE.
  - A reset asserted mid-operation (including mid-debounce or in HIT) takes effect at the next edge and discards everything.
- Synchronizer: two flops per sensor bit.
- Debounce, per sensor:
  - While the synchronized bit equals the filtered bit, the counter is held at 0.
  - While it differs, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the bit still differs, the filtered bit toggles and the counter returns to 0.
  - Any glitch back to the filtered value clears the counter.
  - Pin-to-filtered latency is 2+DEBOUNCE_CYCLES cycles (18 at default).
- Edge detect: rise[i] = filtered[i] & ~filtered_d[i].
- Target change: the registered copy of target_active differs from the input for one cycle.
- FSM:
  - IDLE: armed=0. Stays while target_active ≥ NUM_SENSORS. On a change to a valid index → ARMING with arm counter=0.
  - ARMING: counts ARM_DELAY cycles, then → WATCH. A sensor already lit at entry cannot score until it falls and rises again, because only rising edges count.
  - WATCH: armed=1. On rise[target] → HIT next cycle. Latency from filtered rise to active_is_hit=1 is 1 cycle. hit_count increments on this transition and saturates at 0xFFFF.
  - HIT: active_is_hit=1, armed=0. On hit_clear → WATCH.
- Target change from any state: → ARMING if the new index is valid, else IDLE. active_is_hit clears on the same edge.
- Priority, highest first: reset > target change > hit_clear > rise.
  - Rise and target change in the same cycle: the hit is discarded.
  - hit_clear outside HIT is ignored.
- Multiple rises while in HIT do not increment hit_count.
- Out-of-range index: never indexes photo_array; treated as no target.

Optional Feature:
- Macro: TARGET_HIT_MISS_EN.
- Defined: in WATCH, a rise on any sensor other than the target pulses miss_pulse for 1 cycle. miss_count increments, saturating at 0xFFFF, and clears only on reset. Simultaneous miss and hit in the same cycle: both are recorded.
- Undefined: miss_pulse and miss_count are tied to 0. Ports are kept so the top-level wiring is identical.

Decomposition:
- Shared package ewh_pkg:
  - FSM state encoding: IDLE=2'd0, ARMING=2'd1, WATCH=2'd2, HIT=2'd3.
  - NO_TARGET=4'hF.
  - Count width constant CNT_W=16.
- Sub-module sensor_debounce: synchronizer + debounce counter for one bit, parameterized by DEBOUNCE_CYCLES, instantiated NUM_SENSORS times via generate. The FSM, edge detect and counters stay in the top of the block.

Test Plan:
- Reset, then target_active=3 → armed=1 after 1+8 cycles. Drive photo_array[3]=1 for 30 cycles → active_is_hit=1 exactly 2+16+1 cycles after the pin rise; hit_count=1.
- Glitch photo_array[3] high for 10 cycles (<16) in WATCH → no hit, hit_count unchanged.
- In HIT, pulse hit_clear → active_is_hit=0 next cycle and state WATCH. Re-fire requires a pin fall followed by a clean rise; holding the pin high gives no second hit.
- Sensor 5 already lit, target_active changes 3→5 → state ARMING then WATCH, no hit until the sensor falls and re-rises. target_active=4'hA → armed=0, IDLE, no hit for any sensor activity.
- Filtered rise on target and target change in the same cycle → no hit, hit_count unchanged, ARMING. Force hit_count=0xFFFF, then a hit → stays 0xFFFF.
- With TARGET_HIT_MISS_EN defined, target=2, clean rise on sensor 7 in WATCH → miss_pulse for 1 cycle, miss_count=1, active_is_hit=0. Without the macro → miss_pulse and miss_count stay 0.
